// File: rtl/dmem_mmio_ctrl.sv
// Data-memory and MMIO controller for the M stage: word RAM, I/O page (LED, switches, timer, status).
// Optional timer block is compiled in when DMEM_TIMER_EN is defined.
module dmem_mmio_ctrl #(
    parameter int          RAM_WORDS = 64,
    parameter logic [31:0] IO_BASE   = 32'h0000_FF00,
    parameter int          LED_W     = 8,
    parameter int          SW_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWriteM,
    input  logic [31:0]      ALUOutM,
    input  logic [31:0]      WriteDataM,
    output logic [31:0]      ReadDataM,
    output logic [1:0]       MemorySelector,
    input  logic [SW_W-1:0]  Switches,
    output logic [LED_W-1:0] Leds,
    output logic             TimerIrq
);

    localparam int          AW          = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES_C = 32'(RAM_WORDS * 4);
    localparam logic [1:0]  SEL_RAM     = 2'b00;
    localparam logic [1:0]  SEL_IO      = 2'b01;
    localparam logic [1:0]  SEL_UNMAP   = 2'b10;

    logic [31:0]      mem_r [RAM_WORDS];
    logic [1:0]       sel_s;
    logic [AW-1:0]    ram_idx_s;
    logic [5:0]       io_word_s;
    logic             ram_we_s;
    logic             io_we_s;
    logic             led_we_s;
    logic             status_we_s;
    logic             unmap_set_s;
    logic [LED_W-1:0] led_r;
    logic [SW_W-1:0]  sw_meta_r;
    logic [SW_W-1:0]  sw_sync_r;
    logic             unmap_r;
    logic             match_bit_s;
    logic [31:0]      rdata_s;

    assign ram_idx_s   = ALUOutM[AW+1:2];
    assign io_word_s   = ALUOutM[7:2];
    // Stores are dropped while reset is asserted so nothing leaks past a reset edge.
    assign ram_we_s    = MemWriteM && (sel_s == SEL_RAM) && reset;
    assign io_we_s     = MemWriteM && (sel_s == SEL_IO);
    assign led_we_s    = io_we_s && (io_word_s == 6'd0);
    assign status_we_s = io_we_s && (io_word_s == 6'd4);
    assign unmap_set_s = MemWriteM && (sel_s == SEL_UNMAP);

    // Address decode: RAM has priority over the I/O page should they ever overlap.
    always_comb begin
        sel_s = SEL_UNMAP;
        if (ALUOutM < RAM_BYTES_C) begin
            sel_s = SEL_RAM;
        end else if (ALUOutM[31:8] == IO_BASE[31:8]) begin
            sel_s = SEL_IO;
        end else begin
            sel_s = SEL_UNMAP;
        end
    end

    // Word RAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_r[ram_idx_s] <= WriteDataM;
        end
    end

    // LED register, switch synchronizer and unmapped-write sticky flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            led_r     <= {LED_W{1'b0}};
            sw_meta_r <= {SW_W{1'b0}};
            sw_sync_r <= {SW_W{1'b0}};
            unmap_r   <= 1'b0;
        end else begin
            sw_meta_r <= Switches;
            sw_sync_r <= sw_meta_r;
            if (led_we_s) begin
                led_r <= WriteDataM[LED_W-1:0];
            end
            // Set beats a simultaneous write-one-to-clear.
            unmap_r <= unmap_set_s | (unmap_r & ~(status_we_s & WriteDataM[1]));
        end
    end

`ifdef DMEM_TIMER_EN
    logic [31:0] tcount_r;
    logic [31:0] tcmp_r;
    logic        match_r;
    logic [31:0] tcount_nxt_s;
    logic        tcount_we_s;
    logic        tcmp_we_s;

    assign tcount_we_s  = io_we_s && (io_word_s == 6'd2);
    assign tcmp_we_s    = io_we_s && (io_word_s == 6'd3);
    assign tcount_nxt_s = tcount_we_s ? WriteDataM : (tcount_r + 32'd1);
    assign match_bit_s  = match_r;
    assign TimerIrq     = match_r;

    // Free-running timer; the match flag tracks the value the counter is moving to.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tcount_r <= 32'd0;
            tcmp_r   <= 32'hFFFF_FFFF;
            match_r  <= 1'b0;
        end else begin
            tcount_r <= tcount_nxt_s;
            if (tcmp_we_s) begin
                tcmp_r <= WriteDataM;
            end
            match_r <= (tcount_nxt_s == tcmp_r) | (match_r & ~(status_we_s & WriteDataM[0]));
        end
    end
`else
    assign match_bit_s = 1'b0;
    assign TimerIrq    = 1'b0;
`endif

    // Load data mux; unmapped space and unused I/O offsets read as zero.
    always_comb begin
        rdata_s = 32'd0;
        case (sel_s)
            SEL_RAM: rdata_s = mem_r[ram_idx_s];
            SEL_IO: begin
                case (io_word_s)
                    6'd0:    rdata_s = {{(32-LED_W){1'b0}}, led_r};
                    6'd1:    rdata_s = {{(32-SW_W){1'b0}}, sw_sync_r};
`ifdef DMEM_TIMER_EN
                    6'd2:    rdata_s = tcount_r;
                    6'd3:    rdata_s = tcmp_r;
`endif
                    6'd4:    rdata_s = {30'd0, unmap_r, match_bit_s};
                    default: rdata_s = 32'd0;
                endcase
            end
            default: rdata_s = 32'd0;
        endcase
    end

    assign ReadDataM      = rdata_s;
    assign MemorySelector = sel_s;
    assign Leds           = led_r;

endmodule

// File: tb/tb_dmem_mmio_ctrl.sv
// Self-checking bench for dmem_mmio_ctrl: vector table through a scoreboard queue plus
// hand-written sequences for reset, switch sync latency and the timer (DMEM_TIMER_EN).
module tb_dmem_mmio_ctrl;

    logic        clk;
    logic        reset;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic [1:0]  MemorySelector;
    logic [7:0]  Switches;
    logic [7:0]  Leds;
    logic        TimerIrq;

    int n_cmp;
    int n_err;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [1:0]  exp_sel;
        logic [7:0]  exp_leds;
    } vec_t;

    vec_t tbl [24];
    vec_t sb_q [$];

    dmem_mmio_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .MemWriteM      (MemWriteM),
        .ALUOutM        (ALUOutM),
        .WriteDataM     (WriteDataM),
        .ReadDataM      (ReadDataM),
        .MemorySelector (MemorySelector),
        .Switches       (Switches),
        .Leds           (Leds),
        .TimerIrq       (TimerIrq)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic chk_rd, input logic [31:0] exp_rd,
                                input logic [1:0] exp_sel, input logic [7:0] exp_leds);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.chk_rd = chk_rd;
        v.exp_rd = exp_rd; v.exp_sel = exp_sel; v.exp_leds = exp_leds;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus cycle: drive just after the rising edge, return at the falling edge for sampling.
    task automatic cyc(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk);
        #1;
        MemWriteM  = we;
        ALUOutM    = addr;
        WriteDataM = wdata;
        @(negedge clk);
    endtask

    initial begin
        vec_t e;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        MemWriteM = 1'b0;
        ALUOutM = 32'd0;
        WriteDataM = 32'd0;
        Switches = 8'h00;

        tbl[0]  = mk(1'b1, 32'h0000_0014, 32'h1234_5678, 1'b0, 32'h0,         2'b00, 8'h00);
        tbl[1]  = mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         2'b00, 8'h00);
        tbl[2]  = mk(1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0,         2'b00, 8'h00);
        tbl[3]  = mk(1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 2'b00, 8'h00);
        tbl[4]  = mk(1'b0, 32'h0000_0014, 32'h0,         1'b1, 32'h1234_5678, 2'b00, 8'h00);
        tbl[5]  = mk(1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF, 2'b00, 8'h00);
        tbl[6]  = mk(1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 1'b0, 32'h0,         2'b00, 8'h00);
        tbl[7]  = mk(1'b0, 32'h0000_00FC, 32'h0,         1'b1, 32'hCAFE_F00D, 2'b00, 8'h00);
        tbl[8]  = mk(1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0,         2'b10, 8'h00);
        tbl[9]  = mk(1'b1, 32'h0000_FF00, 32'h0000_01A5, 1'b1, 32'h0,         2'b01, 8'h00);
        tbl[10] = mk(1'b0, 32'h0000_FF00, 32'h0,         1'b1, 32'h0000_00A5, 2'b01, 8'hA5);
        tbl[11] = mk(1'b1, 32'h0000_FF14, 32'hFFFF_FFFF, 1'b1, 32'h0,         2'b01, 8'hA5);
        tbl[12] = mk(1'b0, 32'h0000_FF14, 32'h0,         1'b1, 32'h0,         2'b01, 8'hA5);
        tbl[13] = mk(1'b1, 32'h0000_FF04, 32'h0000_00FF, 1'b1, 32'h0,         2'b01, 8'hA5);
        tbl[14] = mk(1'b0, 32'h0000_FF04, 32'h0,         1'b1, 32'h0,         2'b01, 8'hA5);
        tbl[15] = mk(1'b0, 32'h0000_FF10, 32'h0,         1'b1, 32'h0,         2'b01, 8'hA5);
        tbl[16] = mk(1'b1, 32'h0000_8000, 32'h0000_0055, 1'b1, 32'h0,         2'b10, 8'hA5);
        tbl[17] = mk(1'b0, 32'h0000_FF10, 32'h0,         1'b1, 32'h0000_0002, 2'b01, 8'hA5);
        tbl[18] = mk(1'b0, 32'h0000_FF00, 32'h0,         1'b1, 32'h0000_00A5, 2'b01, 8'hA5);
        tbl[19] = mk(1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h1111_1111, 2'b00, 8'hA5);
        tbl[20] = mk(1'b1, 32'h0000_FF10, 32'h0000_0002, 1'b1, 32'h0000_0002, 2'b01, 8'hA5);
        tbl[21] = mk(1'b0, 32'h0000_FF10, 32'h0,         1'b1, 32'h0,         2'b01, 8'hA5);
        tbl[22] = mk(1'b0, 32'h0001_FF00, 32'h0,         1'b1, 32'h0,         2'b10, 8'hA5);
        tbl[23] = mk(1'b0, 32'hFFFF_FF00, 32'h0,         1'b1, 32'h0,         2'b10, 8'hA5);

        // Reset held for two edges.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_leds", {24'd0, Leds}, 32'd0);
        chk("rst_irq", {31'd0, TimerIrq}, 32'd0);
        chk("rst_sel_addr0", {30'd0, MemorySelector}, 32'd0);
        ALUOutM = 32'h0000_FF0C;
        #1;
`ifdef DMEM_TIMER_EN
        chk("rst_tcmp", ReadDataM, 32'hFFFF_FFFF);
`else
        chk("rst_tcmp_off", ReadDataM, 32'h0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Table vectors through the scoreboard.
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            MemWriteM  = tbl[i].we;
            ALUOutM    = tbl[i].addr;
            WriteDataM = tbl[i].wdata;
            sb_q.push_back(tbl[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            chk($sformatf("vec%0d_sel", i), {30'd0, MemorySelector}, {30'd0, e.exp_sel});
            chk($sformatf("vec%0d_leds", i), {24'd0, Leds}, {24'd0, e.exp_leds});
            if (e.chk_rd) begin
                chk($sformatf("vec%0d_rd", i), ReadDataM, e.exp_rd);
            end
        end

        // Switch synchronizer: two edges from pin to readable value.
        cyc(1'b0, 32'h0000_FF04, 32'h0);
        Switches = 8'h3C;
        #1;
        chk("sw_edge0", ReadDataM, 32'h0);
        cyc(1'b0, 32'h0000_FF04, 32'h0);
        chk("sw_edge1", ReadDataM, 32'h0);
        cyc(1'b0, 32'h0000_FF04, 32'h0);
        chk("sw_edge2", ReadDataM, 32'h0000_003C);

`ifdef DMEM_TIMER_EN
        // Compare match five cycles after loading the counter, then W1C clear.
        cyc(1'b1, 32'h0000_FF0C, 32'd5);
        cyc(1'b1, 32'h0000_FF08, 32'd0);
        cyc(1'b0, 32'h0000_FF08, 32'h0);
        chk("tmr_load", ReadDataM, 32'd0);
        chk("tmr_irq_load", {31'd0, TimerIrq}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            cyc(1'b0, 32'h0000_FF08, 32'h0);
            chk($sformatf("tmr_cnt%0d", k), ReadDataM, 32'(k));
            chk($sformatf("tmr_irq%0d", k), {31'd0, TimerIrq}, (k == 5) ? 32'd1 : 32'd0);
        end
        cyc(1'b1, 32'h0000_FF10, 32'd1);
        chk("tmr_status_set", ReadDataM, 32'd1);
        cyc(1'b0, 32'h0000_FF08, 32'h0);
        chk("tmr_irq_clr", {31'd0, TimerIrq}, 32'd0);
        chk("tmr_running", ReadDataM, 32'd7);

        // Set and clear in the same cycle: set wins.
        cyc(1'b1, 32'h0000_FF0C, 32'd100);
        cyc(1'b1, 32'h0000_FF08, 32'd99);
        cyc(1'b1, 32'h0000_FF10, 32'd1);
        cyc(1'b0, 32'h0000_FF10, 32'h0);
        chk("tmr_set_wins", ReadDataM, 32'd1);
        chk("tmr_set_wins_irq", {31'd0, TimerIrq}, 32'd1);

        // Loading the counter with the compare value also sets the flag.
        cyc(1'b1, 32'h0000_FF10, 32'd1);
        cyc(1'b1, 32'h0000_FF08, 32'd100);
        chk("tmr_preload_irq", {31'd0, TimerIrq}, 32'd0);
        cyc(1'b0, 32'h0000_FF10, 32'h0);
        chk("tmr_load_eq", ReadDataM, 32'd1);
        chk("tmr_load_eq_irq", {31'd0, TimerIrq}, 32'd1);
`else
        // Timer disabled: offsets read zero, flag and irq stay low.
        cyc(1'b1, 32'h0000_FF0C, 32'd5);
        cyc(1'b1, 32'h0000_FF08, 32'd4);
        cyc(1'b0, 32'h0000_FF0C, 32'h0);
        chk("notmr_tcmp", ReadDataM, 32'h0);
        cyc(1'b0, 32'h0000_FF08, 32'h0);
        chk("notmr_tcount", ReadDataM, 32'h0);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 32'h0000_FF10, 32'h0);
        end
        chk("notmr_status", ReadDataM, 32'h0);
        chk("notmr_irq", {31'd0, TimerIrq}, 32'd0);
`endif

        // Reset arriving with a store: the reset value wins.
        @(posedge clk);
        #1;
        reset      = 1'b0;
        MemWriteM  = 1'b1;
        ALUOutM    = 32'h0000_FF00;
        WriteDataM = 32'h0000_0077;
        @(posedge clk);
        #1;
        reset     = 1'b1;
        MemWriteM = 1'b0;
        @(negedge clk);
        chk("rstst_leds", {24'd0, Leds}, 32'd0);
        chk("rstst_rd", ReadDataM, 32'd0);
        chk("rstst_irq", {31'd0, TimerIrq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
